datapath_pipe: RTL and testbench
================================

DATAPATH_PIPE -- requirements
Module: datapath_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the datapath and register width; legal range 16..64.
REQ-002 The block SHALL have parameter REG_N, default 32, giving the register count; power of two, 4..32, address width clog2(REG_N).
REQ-003 The block SHALL have parameter PC_W, default 32, giving the program counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: pipeline advance; 0 freezes every register, including the register file.
REQ-007 The block SHALL have port imem_addr, output, PC_W bits: fetch address, equal to the PC register.
REQ-008 The block SHALL have port imem_rdata, input, 32 bits: instruction at imem_addr, combinational in the same cycle.
REQ-009 The block SHALL have port wb_valid, output, 1 bit: a retiring instruction is in the WB stage.
REQ-010 The block SHALL have port wb_addr, output, clog2(REG_N) bits: destination register of the retiring instruction.
REQ-011 The block SHALL have port fim, output, DATA_W bits: result of the retiring instruction.

Function
REQ-012 Instruction fields SHALL be: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[3:0], imm[15:0]; register fields truncated to clog2(REG_N) bits.
REQ-013 Decode SHALL support: op 0x00 R-type, rd = rs OP(funct) rt; 0x08 ADDI, rt = rs + sign-extended imm; 0x0C ANDI and 0x0D ORI, rt = rs AND/OR zero-extended imm.
REQ-014 Any other opcode SHALL be a NOP: it travels the pipe with valid=0 and causes no write.
REQ-015 ALU codes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed, result 1 or 0), 7 SLTU; codes 8-15 yield 0 and still write.
REQ-016 Arithmetic SHALL be modulo 2^DATA_W; no overflow flag or trap.
REQ-017 Immediates SHALL be extended to DATA_W bits.
REQ-018 There SHALL be three stages. IF: PC drives imem_addr, and imem_rdata is captured into the IF/EX register. EX: decode, register read, forwarding, ALU, with the result captured into the EX/WB register. WB: the EX/WB register drives wb_valid/wb_addr/fim and writes the register file.
REQ-019 While en=1, PC SHALL advance by 4 per cycle, wrapping modulo 2^PC_W.
REQ-020 Latency SHALL be: an instruction present at imem_rdata in cycle n appears at fim in cycle n+2 (two rising edges with en=1).
REQ-021 Register 0 SHALL read as zero; writes to it are discarded, and a retiring write to it sets wb_valid=1, wb_addr=0 with fim showing the computed value.
REQ-022 Forwarding SHALL apply when the WB stage holds a valid write to register r≠0: an EX read of r takes the WB result instead of the register-file value, independently for rs and rt.
REQ-023 Back-to-back dependencies SHALL resolve without stalls; there is no hazard stall logic.
REQ-024 While en=0, all outputs SHALL hold their values and no register-file write occurs; on resuming, execution continues exactly as if uninterrupted.
REQ-025 When rst and en are both asserted, rst SHALL win.

Reset
REQ-026 Reset SHALL force: PC = 0, IF/EX and EX/WB valid = 0, all registers = 0, wb_valid = 0, wb_addr = 0, fim = 0.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight instructions, with no write on that edge.
REQ-028 The first fetch after reset release SHALL be address 0.

Structure
REQ-029 A shared package datapath_pkg SHALL hold opcode constants, the ALU-op enum, instruction field positions and the NOP encoding.
REQ-030 The register file SHALL be a sub-module, regfile_p, parametrised by DATA_W and REG_N, with 2 combinational read ports, 1 synchronous write port and a sync reset.
REQ-031 ALU and decode SHALL be combinational logic inside datapath_pipe.

Verification
REQ-032 Reset release, en=1, ADDI r1,r0,5 at address 0 -> imem_addr 0,4,8; fim=5, wb_addr=1, wb_valid=1 two edges after the fetch.
REQ-033 ADDI r1,r0,-1 followed immediately by ADD r2,r1,r1 -> second result fim=0xFFFF_FFFE, showing forwarding with no bubble.
REQ-034 r3=0x7FFF_FFFF, then ADD r4,r3,r3 and SLT r5,r4,r0 -> r4=0xFFFF_FFFE (wrap), r5=1.
REQ-035 ADDI r0,r0,9, then ADD r6,r0,r0 -> first retires with r0 unchanged; r6 result 0 (no forwarding from r0).
REQ-036 en=0 for 3 cycles mid-stream -> outputs frozen and imem_addr constant; the results sequence is identical to the en=1 run.
REQ-037 rst pulsed while two instructions are in flight -> next cycle wb_valid=0, fim=0, imem_addr=0, and r1 reads 0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared constants for the three-stage datapath: instruction fields, opcodes,
// ALU operation codes and the bubble instruction used after reset.
package datapath_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned OP_W      = 6;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned FUNCT_W   = 4;
    localparam int unsigned IMM_LSB   = 0;
    localparam int unsigned IMM_W     = 16;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;

    // Opcode 0x3F decodes as a no-op.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hFC00_0000;

    typedef enum logic [FUNCT_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7
    } alu_op_e;

endpackage

// File: rtl/regfile_p.sv
// Register file: two combinational read ports, one synchronous write port,
// synchronous reset; register 0 is hard-wired to zero.
module regfile_p #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_N  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(REG_N)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(REG_N)-1:0] raddr_a,
    output logic [DATA_W-1:0]        rdata_a_c,
    input  logic [$clog2(REG_N)-1:0] raddr_b,
    output logic [DATA_W-1:0]        rdata_b_c
);

    logic [DATA_W-1:0] mem [REG_N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_N); i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a_c = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b_c = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/datapath_pipe.sv
// Three-stage (IF / EX / WB) integer datapath with WB->EX forwarding and a
// global advance enable; no stall logic.
module datapath_pipe
    import datapath_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_N  = 32,
    parameter int unsigned PC_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    output logic [PC_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]       imem_rdata,
    output logic                     wb_valid,
    output logic [$clog2(REG_N)-1:0] wb_addr,
    output logic [DATA_W-1:0]        fim
);

    localparam int unsigned AW = $clog2(REG_N);

    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] if_instr;
    logic               if_valid;

    logic [OP_W-1:0]    op;
    logic [AW-1:0]      rs_a;
    logic [AW-1:0]      rt_a;
    logic [AW-1:0]      rd_a;
    logic [IMM_W-1:0]   imm;
    logic [DATA_W-1:0]  imm_s;
    logic [DATA_W-1:0]  imm_z;
    logic [DATA_W-1:0]  rs_rf;
    logic [DATA_W-1:0]  rt_rf;
    logic [DATA_W-1:0]  rs_val;
    logic [DATA_W-1:0]  rt_val;
    logic               fwd_ok;

    logic               ex_valid;
    logic [AW-1:0]      ex_dst;
    alu_op_e            alu_op;
    logic [DATA_W-1:0]  opb;
    logic [DATA_W-1:0]  alu_res;
    logic               unused_instr;

    assign imem_addr = pc;

    assign op    = if_instr[OP_LSB +: OP_W];
    assign rs_a  = if_instr[RS_LSB +: AW];
    assign rt_a  = if_instr[RT_LSB +: AW];
    assign rd_a  = if_instr[RD_LSB +: AW];
    assign imm   = if_instr[IMM_LSB +: IMM_W];
    assign imm_s = DATA_W'($signed(imm));
    assign imm_z = DATA_W'(imm);

    assign unused_instr = ^if_instr;

    regfile_p #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .we        (en && wb_valid),
        .waddr     (wb_addr),
        .wdata     (fim),
        .raddr_a   (rs_a),
        .rdata_a_c (rs_rf),
        .raddr_b   (rt_a),
        .rdata_b_c (rt_rf)
    );

    // The WB result is written on the same edge EX captures, so bypass it.
    assign fwd_ok = wb_valid && (wb_addr != '0);
    assign rs_val = (fwd_ok && (wb_addr == rs_a)) ? fim : rs_rf;
    assign rt_val = (fwd_ok && (wb_addr == rt_a)) ? fim : rt_rf;

    always_comb begin
        ex_valid = 1'b0;
        ex_dst   = '0;
        alu_op   = ALU_ADD;
        opb      = rt_val;
        unique case (op)
            OP_RTYPE: begin
                ex_valid = if_valid;
                ex_dst   = rd_a;
                alu_op   = alu_op_e'(if_instr[FUNCT_LSB +: FUNCT_W]);
            end
            OP_ADDI: begin
                ex_valid = if_valid;
                ex_dst   = rt_a;
                opb      = imm_s;
            end
            OP_ANDI: begin
                ex_valid = if_valid;
                ex_dst   = rt_a;
                alu_op   = ALU_AND;
                opb      = imm_z;
            end
            OP_ORI: begin
                ex_valid = if_valid;
                ex_dst   = rt_a;
                alu_op   = ALU_OR;
                opb      = imm_z;
            end
            default: ex_valid = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = rs_val + opb;
            ALU_SUB:  alu_res = rs_val - opb;
            ALU_AND:  alu_res = rs_val & opb;
            ALU_OR:   alu_res = rs_val | opb;
            ALU_XOR:  alu_res = rs_val ^ opb;
            ALU_NOR:  alu_res = ~(rs_val | opb);
            ALU_SLT:  alu_res = DATA_W'($signed(rs_val) < $signed(opb));
            ALU_SLTU: alu_res = DATA_W'(rs_val < opb);
            default:  alu_res = '0;
        endcase
    end

    // Pipeline registers: reset dominates, en=0 holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            fim      <= '0;
        end else if (en) begin
            pc       <= pc + PC_W'(4);
            if_instr <= imem_rdata;
            if_valid <= 1'b1;
            wb_valid <= ex_valid;
            wb_addr  <= ex_valid ? ex_dst : '0;
            fim      <= ex_valid ? alu_res : '0;
        end
    end

endmodule

// File: tb/tb_datapath_pipe.sv
// Scoreboard bench for datapath_pipe: directed programs, expected retirements
// queued at fetch and compared by an independent monitor at WB.
module tb_datapath_pipe;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] fim;

    logic        phase;
    logic [31:0] prog_a [64];
    logic [31:0] prog_b [64];
    exp_t        exp_a  [64];
    exp_t        exp_b  [64];
    logic        has_a  [64];
    logic        has_b  [64];
    logic [5:0]  idx;

    exp_t        sb [$];
    int          total;
    int          bad;
    int          retired;
    logic [31:0] exp_pc;

    datapath_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .fim        (fim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign idx        = imem_addr[7:2];
    assign imem_rdata = phase ? prog_b[idx] : prog_a[idx];

    function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [3:0] f);
        return {6'h00, rs, rt, rd, 7'd0, f};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rt,
                                           input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic put_a(input int p, input logic [31:0] ins, input logic v,
                         input logic [4:0] a, input logic [31:0] d);
        prog_a[p] = ins;
        has_a[p]  = v;
        exp_a[p]  = '{addr: a, data: d};
    endtask

    task automatic put_b(input int p, input logic [31:0] ins, input logic v,
                         input logic [4:0] a, input logic [31:0] d);
        prog_b[p] = ins;
        has_b[p]  = v;
        exp_b[p]  = '{addr: a, data: d};
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected results enter the scoreboard when an instruction is fetched.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
        end else if (en) begin
            if (phase ? has_b[idx] : has_a[idx])
                sb.push_back(phase ? exp_b[idx] : exp_a[idx]);
        end
    end

    // Monitor: one retirement per advancing edge with wb_valid high.
    initial begin : monitor
        logic en_s;
        logic rst_s;
        exp_t e;
        forever begin
            @(posedge clk);
            en_s  = en;
            rst_s = rst;
            #1;
            if (!rst_s && en_s && wb_valid) begin
                retired++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_retire: got wb_addr=%0d fim=0x%0h, expected none",
                             wb_addr, fim);
                end else begin
                    e = sb.pop_front();
                    check("wb_addr", 64'(wb_addr), 64'(e.addr));
                    check("fim",     64'(fim),     64'(e.data));
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (en) exp_pc += 32'd4;
        check("imem_addr", 64'(imem_addr), 64'(exp_pc));
    endtask

    initial begin : driver
        logic        snap_v;
        logic [4:0]  snap_a;
        logic [31:0] snap_d;
        int          guard;

        total   = 0;
        bad     = 0;
        retired = 0;
        phase   = 1'b0;
        rst     = 1'b1;
        en      = 1'b1;
        exp_pc  = 32'd0;
        for (int i = 0; i < 64; i++) begin
            put_a(i, 32'hFC00_0000, 1'b0, 5'd0, 32'd0);
            put_b(i, 32'hFC00_0000, 1'b0, 5'd0, 32'd0);
        end

        put_a(0,  i_type(6'h08, 5'd1, 5'd0, 16'd5),      1, 5'd1,  32'd5);
        put_a(1,  i_type(6'h08, 5'd1, 5'd0, 16'hFFFF),   1, 5'd1,  32'hFFFF_FFFF);
        put_a(2,  r_type(5'd2, 5'd1, 5'd1, 4'd0),        1, 5'd2,  32'hFFFF_FFFE);
        put_a(3,  i_type(6'h0D, 5'd8, 5'd0, 16'h8000),   1, 5'd8,  32'h0000_8000);
        for (int k = 1; k <= 16; k++)
            put_a(3 + k, r_type(5'd8, 5'd8, 5'd8, 4'd0), 1, 5'd8,  32'h0000_8000 << k);
        put_a(20, r_type(5'd3,  5'd8,  5'd0, 4'd5),      1, 5'd3,  32'h7FFF_FFFF);
        put_a(21, r_type(5'd4,  5'd3,  5'd3, 4'd0),      1, 5'd4,  32'hFFFF_FFFE);
        put_a(22, r_type(5'd5,  5'd4,  5'd0, 4'd6),      1, 5'd5,  32'd1);
        put_a(23, r_type(5'd10, 5'd4,  5'd0, 4'd7),      1, 5'd10, 32'd0);
        put_a(24, r_type(5'd11, 5'd0,  5'd3, 4'd1),      1, 5'd11, 32'h8000_0001);
        put_a(25, r_type(5'd12, 5'd4,  5'd3, 4'd4),      1, 5'd12, 32'h8000_0001);
        put_a(26, r_type(5'd13, 5'd12, 5'd3, 4'd2),      1, 5'd13, 32'd1);
        put_a(27, r_type(5'd14, 5'd13, 5'd8, 4'd3),      1, 5'd14, 32'h8000_0001);
        put_a(28, i_type(6'h0C, 5'd15, 5'd4, 16'hF0F0),  1, 5'd15, 32'h0000_F0F0);
        put_a(29, i_type(6'h0D, 5'd16, 5'd0, 16'hFFFF),  1, 5'd16, 32'h0000_FFFF);
        put_a(30, r_type(5'd17, 5'd4,  5'd3, 4'd9),      1, 5'd17, 32'd0);
        put_a(31, 32'hFC00_0000,                         0, 5'd0,  32'd0);
        put_a(32, i_type(6'h08, 5'd0, 5'd0, 16'd9),      1, 5'd0,  32'd9);
        put_a(33, r_type(5'd6,  5'd0,  5'd0, 4'd0),      1, 5'd6,  32'd0);
        put_a(34, r_type(5'd18, 5'd0,  5'd4, 4'd6),      1, 5'd18, 32'd0);
        put_a(35, r_type(5'd19, 5'd0,  5'd4, 4'd7),      1, 5'd19, 32'd1);
        put_a(36, i_type(6'h08, 5'd20, 5'd16, 16'hFFFF), 1, 5'd20, 32'h0000_FFFE);
        put_a(40, i_type(6'h08, 5'd1, 5'd0, 16'h55),     1, 5'd1,  32'h55);
        put_a(41, i_type(6'h08, 5'd3, 5'd0, 16'h66),     1, 5'd3,  32'h66);

        put_b(0, r_type(5'd7,  5'd1, 5'd0, 4'd0),        1, 5'd7,  32'd0);
        put_b(1, r_type(5'd9,  5'd3, 5'd0, 4'd0),        1, 5'd9,  32'd0);
        put_b(2, r_type(5'd21, 5'd8, 5'd0, 4'd0),        1, 5'd21, 32'd0);
        put_b(3, i_type(6'h08, 5'd22, 5'd0, 16'd3),      1, 5'd22, 32'd3);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        check("rst_wb_valid",  64'(wb_valid),  64'd0);
        check("rst_wb_addr",   64'(wb_addr),   64'd0);
        check("rst_fim",       64'(fim),       64'd0);
        rst = 1'b0;
        check("first_fetch", 64'(imem_addr), 64'd0);

        for (int i = 0; i < 12; i++) step();

        // Freeze for three cycles mid-stream
        en     = 1'b0;
        snap_v = wb_valid;
        snap_a = wb_addr;
        snap_d = fim;
        for (int i = 0; i < 3; i++) begin
            step();
            check("frz_wb_valid", 64'(wb_valid), 64'(snap_v));
            check("frz_wb_addr",  64'(wb_addr),  64'(snap_a));
            check("frz_fim",      64'(fim),      64'(snap_d));
        end
        en = 1'b1;

        guard = 0;
        while (imem_addr != 32'd168 && guard < 200) begin
            step();
            guard++;
        end
        check("reach_addr_168", 64'(imem_addr), 64'd168);

        // Reset with instructions 40 and 41 in flight
        rst   = 1'b1;
        phase = 1'b1;
        @(negedge clk);
        check("midrst_wb_valid",  64'(wb_valid),  64'd0);
        check("midrst_fim",       64'(fim),       64'd0);
        check("midrst_wb_addr",   64'(wb_addr),   64'd0);
        check("midrst_imem_addr", 64'(imem_addr), 64'd0);
        rst    = 1'b0;
        exp_pc = 32'd0;
        for (int i = 0; i < 8; i++) step();

        check("sb_drained", 64'(sb.size()), 64'd0);
        check("retire_count", 64'(retired), 64'd41);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
